// File: rtl/booth_iter_mult_if.sv
// Operand/product handshake bundle for booth_iter_mult.
interface booth_iter_mult_if #(
  parameter int unsigned C_MANT = 23
);
  localparam int unsigned W = C_MANT + 1;

  logic           In_valid_SI;
  logic           In_ready_SO;
  logic [W-1:0]   Mant_a_DI;
  logic [W-1:0]   Mant_b_DI;
  logic           Out_valid_SO;
  logic           Out_ready_SI;
  logic [2*W-1:0] Prod_DO;
  logic           Busy_SO;

  modport master (
    output In_valid_SI, Mant_a_DI, Mant_b_DI, Out_ready_SI,
    input  In_ready_SO, Out_valid_SO, Prod_DO, Busy_SO
  );

  modport slave (
    input  In_valid_SI, Mant_a_DI, Mant_b_DI, Out_ready_SI,
    output In_ready_SO, Out_valid_SO, Prod_DO, Busy_SO
  );
endinterface

// File: rtl/booth_iter_mult.sv
// Iterative radix-4 Booth mantissa multiplier, C_PP_PER_CYC partial products per cycle.
// Optional macro FPU_BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module booth_iter_mult #(
  parameter int unsigned C_MANT       = 23,
  parameter int unsigned C_PP_PER_CYC = 4
) (
  input  logic              Clk_CI,
  input  logic              Rst_RBI,
  booth_iter_mult_if.slave  bus
);

  localparam int unsigned W    = C_MANT + 1;
  localparam int unsigned NPP  = (W + 2) / 2;
  localparam int unsigned P    = C_PP_PER_CYC;
  localparam int unsigned NCYC = (NPP + P - 1) / P;
  localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int unsigned AW   = 2 * W + 2;
  localparam int unsigned BW   = 2 * P * NCYC + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    a_sh_q, a_sh_d;
  logic [BW-1:0]    b_q, b_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, valid_q, busy_q;
  logic [2*W-1:0]   prod_q;
  logic [AW-1:0]    pp_sum;
  logic [BW-1:0]    b_shift;
  logic             rest_zero;

  assign b_shift = b_q >> (2 * P);

`ifdef FPU_BOOTH_EARLY_TERM_EN
  assign rest_zero = (b_shift == '0);
`else
  assign rest_zero = 1'b0;
`endif

  // Sum of this group's Booth terms; the accumulator runs modulo 2^AW, final product is exact.
  always_comb begin
    pp_sum = '0;
    for (int unsigned j = 0; j < P; j++) begin
      logic [2:0]    trip;
      logic [AW-1:0] mag;
      trip = b_q[2*j +: 3];
      mag  = '0;
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = a_sh_q << (2 * j);
        3'b011, 3'b100:                 mag = a_sh_q << (2 * j + 1);
        default:                        mag = '0;
      endcase
      if ((32'(cnt_q) * P + j) >= NPP) mag = '0;
      pp_sum = trip[2] ? (pp_sum - mag) : (pp_sum + mag);
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ready_q && bus.In_valid_SI) begin
          a_sh_d  = AW'(bus.Mant_a_DI);
          b_d     = BW'({bus.Mant_b_DI, 1'b0});
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = acc_q + pp_sum;
        a_sh_d = a_sh_q << (2 * P);
        b_d    = b_shift;
        cnt_d  = cnt_q + CW'(1);
        if ((cnt_q == CW'(NCYC - 1)) || rest_zero) state_d = DONE;
      end
      DONE: begin
        if (bus.Out_ready_SI) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d == BUSY);
      if ((state_q == BUSY) && (state_d == DONE)) prod_q <= acc_d[2*W-1:0];
    end
  end

  assign bus.In_ready_SO  = ready_q;
  assign bus.Out_valid_SO = valid_q;
  assign bus.Busy_SO      = busy_q;
  assign bus.Prod_DO      = prod_q;

endmodule

// File: tb/tb_booth_iter_mult.sv
// Directed/table-driven bench for booth_iter_mult at C_MANT=23, P=4.
module tb_booth_iter_mult;

  localparam int unsigned C_MANT = 23;
  localparam int unsigned P      = 4;
  localparam int unsigned W      = C_MANT + 1;
  localparam int          NCYC   = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_iter_mult_if #(.C_MANT(C_MANT)) bus_if ();

  booth_iter_mult #(.C_MANT(C_MANT), .C_PP_PER_CYC(P)) dut (
    .Clk_CI  (clk),
    .Rst_RBI (rst_n),
    .bus     (bus_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    int             lat_et;
  } vec_t;

  // lat < 0 means "anywhere in 1..NCYC"
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p, input int lat, input string name);
    int cyc;
    cyc = 0;
    while (!bus_if.In_ready_SO && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " ready"}, 64'(bus_if.In_ready_SO), 64'd1);
    bus_if.In_valid_SI = 1'b1;
    bus_if.Mant_a_DI   = a;
    bus_if.Mant_b_DI   = b;
    @(negedge clk);
    bus_if.In_valid_SI = 1'b0;
    check({name, " busy"}, 64'(bus_if.Busy_SO), 64'd1);
    cyc = 0;
    while (!bus_if.Out_valid_SO && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (lat < 0) check({name, " lat<=NCYC"}, 64'(cyc >= 1 && cyc <= NCYC), 64'd1);
    else         check({name, " lat"}, 64'(cyc), 64'(lat));
    check({name, " valid"}, 64'(bus_if.Out_valid_SO), 64'd1);
    check({name, " prod"}, 64'(bus_if.Prod_DO), 64'(p));
    check({name, " acc_hi"}, 64'(dut.acc_q[2*W+1:2*W]), 64'd0);
    bus_if.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus_if.Out_ready_SI = 1'b0;
    check({name, " drained"}, 64'({bus_if.Out_valid_SO, bus_if.In_ready_SO}), 64'b01);
  endtask

  function automatic int pick_lat(input int lat_et);
`ifdef FPU_BOOTH_EARLY_TERM_EN
    return lat_et;
`else
    return (lat_et < 0) ? NCYC : NCYC;
`endif
  endfunction

  vec_t vecs[11];

  initial begin
    logic [W-1:0] ra, rb;
    logic         saw_valid;

    vecs[0]  = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001, 4};
    vecs[1]  = '{24'h800000, 24'h800000, 48'h400000000000, 4};
    vecs[2]  = '{24'hABCDEF, 24'h000001, 48'h000000ABCDEF, 1};
    vecs[3]  = '{24'h000000, 24'hFFFFFF, 48'h000000000000, 4};
    vecs[4]  = '{24'hFFFFFF, 24'h000000, 48'h000000000000, 1};
    vecs[5]  = '{24'h000001, 24'h000001, 48'h000000000001, 1};
    vecs[6]  = '{24'h800000, 24'h000002, 48'h000001000000, 1};
    vecs[7]  = '{24'hFFFFFF, 24'h000100, 48'h0000FFFFFF00, 2};
    vecs[8]  = '{24'h00FFFF, 24'h00FFFF, 48'h0000FFFE0001, 3};
    vecs[9]  = '{24'h800000, 24'hFFFFFF, 48'h7FFFFF800000, 4};
    vecs[10] = '{24'h000001, 24'h800000, 48'h000000800000, 4};

    bus_if.In_valid_SI  = 1'b0;
    bus_if.Mant_a_DI    = '0;
    bus_if.Mant_b_DI    = '0;
    bus_if.Out_ready_SI = 1'b0;

    repeat (3) @(negedge clk);
    check("reset outs", 64'({bus_if.In_ready_SO, bus_if.Out_valid_SO, bus_if.Busy_SO}), 64'd0);
    check("reset prod", 64'(bus_if.Prod_DO), 64'd0);
    rst_n = 1'b1;
    bus_if.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus_if.Out_ready_SI = 1'b0;
    check("idle ready", 64'({bus_if.In_ready_SO, bus_if.Out_valid_SO}), 64'b10);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p, pick_lat(vecs[i].lat_et), $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef FPU_BOOTH_EARLY_TERM_EN
      run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), -1, $sformatf("rnd%0d", i));
`else
      run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), NCYC, $sformatf("rnd%0d", i));
`endif
    end

    // Backpressure in DONE with input pulses that must be ignored
    bus_if.In_valid_SI = 1'b1;
    bus_if.Mant_a_DI   = 24'hFFFFFF;
    bus_if.Mant_b_DI   = 24'hFFFFFF;
    @(negedge clk);
    bus_if.In_valid_SI = 1'b0;
    for (int c = 0; c < 20 && !bus_if.Out_valid_SO; c++) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      bus_if.In_valid_SI = c[0];
      bus_if.Mant_a_DI   = 24'h000001;
      bus_if.Mant_b_DI   = 24'h000001;
      @(negedge clk);
      check($sformatf("bp%0d state", c),
            64'({bus_if.Out_valid_SO, bus_if.In_ready_SO, bus_if.Busy_SO}), 64'b100);
      check($sformatf("bp%0d prod", c), 64'(bus_if.Prod_DO), 64'hFFFFFE000001);
    end
    bus_if.In_valid_SI  = 1'b0;
    bus_if.Out_ready_SI = 1'b1;
    @(negedge clk);
    bus_if.Out_ready_SI = 1'b0;
    check("bp release", 64'({bus_if.Out_valid_SO, bus_if.In_ready_SO}), 64'b01);
    run_op(24'h000003, 24'h000005, 48'hF, pick_lat(1), "after_bp");

    // Synchronous reset sampled at the second BUSY edge
    bus_if.In_valid_SI = 1'b1;
    bus_if.Mant_a_DI   = 24'hABCDEF;
    bus_if.Mant_b_DI   = 24'hFFFFFF;
    @(negedge clk);
    bus_if.In_valid_SI = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset outs", 64'({bus_if.In_ready_SO, bus_if.Out_valid_SO, bus_if.Busy_SO}), 64'd0);
    check("midreset prod", 64'(bus_if.Prod_DO), 64'd0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_if.Out_valid_SO) saw_valid = 1'b1;
    end
    check("midreset no valid", 64'(saw_valid), 64'd0);
    run_op(24'hABCDEF, 24'hFFFFFF, 48'hABCDEE543211, pick_lat(4), "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_iter_mult.md
# booth_iter_mult

Iterative, parametrised radix-4 Booth mantissa multiplier for the FMAC datapath. It computes the exact unsigned product of two (C_MANT+1)-bit mantissas. Each cycle it accumulates C_PP_PER_CYC Booth partial products, which trades area for latency. The fully parallel partial-product generator cannot make that trade. The block sits between operand pre-normalisation and the FMAC addend alignment/normalisation stage, with valid/ready handshakes on both sides.

## Interface
- C_MANT, 23: mantissa width without hidden bit; operand width W = C_MANT+1
- C_PP_PER_CYC, 4: Booth partial products accumulated per cycle, 1..NPP
- Derived: NPP = (W+2)/2 (integer division; 13 for W=24); NCYC = ceil(NPP/C_PP_PER_CYC)
- Clk_CI  in  1  clock, rising edge
- Rst_RBI  in  1  reset, synchronous, active-low
- In_valid_SI  in  1  operand pair valid
- In_ready_SO  out  1  block can accept operands
- Mant_a_DI  in  W  multiplicand, unsigned, hidden bit included
- Mant_b_DI  in  W  multiplier, unsigned, Booth-recoded
- Out_valid_SO  out  1  product valid
- Out_ready_SI  in  1  downstream accepts product
- Prod_DO  out  2W  exact product Mant_a_DI*Mant_b_DI
- Busy_SO  out  1  high in BUSY state

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - In_ready_SO=1.
  - On In_valid_SI at an edge: latch a, latch b padded as {zeros, b, 1'b0}, clear the accumulator and group counter, then go to BUSY.
- BUSY, group k = 0..NCYC-1:
  - Per edge, recode digits i = k·P .. k·P+P-1 with i<NPP, from b bits {2i+1, 2i, 2i-1} (b[-1]=0) into {-2,-1,0,+1,+2}.
  - Add d_i·a·4^i to a signed accumulator of width 2W+2.
  - Digits with i≥NPP contribute 0.
  - The multiplier register shifts right 2·P bits per group.
  - Go to DONE when k=NCYC-1 (or on early termination).
- DONE:
  - Out_valid_SO=1 and Prod_DO = accumulator[2W-1:0]. The upper accumulator bits are zero by construction, and the bench asserts this.
  - Prod_DO and Out_valid_SO stay stable while Out_ready_SI=0.
  - When Out_ready_SI=1 at an edge, go to IDLE.
- In_valid_SI is ignored outside IDLE. There is no bypass from DONE to a new accept: a DONE→IDLE→accept sequence costs one bubble cycle.
- Operands of zero are legal. a=0 gives a product of 0 after the normal latency.
- Arithmetic is exact with no rounding and no sticky output. Rounding belongs to the downstream normaliser.

## Timing
- Reset values:
  - In_ready_SO=0 while Rst_RBI=0, then 1 in IDLE.
  - Out_valid_SO=0, Busy_SO=0, Prod_DO=0.
  - The accumulator, counter and operand registers are cleared.
- Latency: accept edge E0, groups processed at edges E1..E_NCYC. Out_valid_SO is high in the cycle after E_NCYC.
  - C_MANT=23, P=4: product visible 4 cycles after accept.
- Throughput: one product per NCYC+2 cycles when Out_ready_SI is held high.
- Reset asserted mid-operation (BUSY or DONE): at the next edge, go to IDLE with all outputs at reset values. The partial result is discarded and no product is emitted.
- Out_ready_SI high outside DONE has no effect.

## Configuration
- FPU_BOOTH_EARLY_TERM_EN defined:
  - At each BUSY edge, after accumulating group k, check the remaining multiplier bits. These are b bits at positions ≥ 2·P·(k+1)-1, including the overlap bit.
  - If they are all zero, go to DONE immediately. Latency becomes 1..NCYC.
- Not defined: latency is always exactly NCYC, and the zero-detect logic is absent.
- The product value is identical in both builds.

## Test plan
- C_MANT=23, P=4: a=b=0xFFFFFF → Prod_DO=0xFFFFFE000001, Out_valid_SO high 4 cycles after accept.
- a=b=0x800000 → Prod_DO=0x400000000000. Latency is 4 in both builds, because the top digit (+1) is in the last group.
- With FPU_BOOTH_EARLY_TERM_EN, a=0xABCDEF, b=0x000001 → Prod_DO=0xABCDEF after 1 cycle. Without the macro, the same product arrives after 4 cycles.
- Backpressure: hold Out_ready_SI=0 for 5 cycles in DONE and pulse In_valid_SI meanwhile. Out_valid_SO and Prod_DO must stay stable and In_ready_SO=0. Release → IDLE, next operand accepted one cycle later.
- Reset: drive Rst_RBI=0 at the second BUSY edge. All outputs return to 0, no Out_valid_SO pulse occurs, and the next operation returns a correct product.
- Sweep C_MANT ∈ {10, 23, 52} and P ∈ {1, 3, NPP}: 1000 random plus corner operands each (0, 1, all-ones, hidden-bit-only). Compare Prod_DO against a·b, check latency against NCYC (or ≤NCYC with early termination), and check that the accumulator bits above 2W-1 are zero.
